// File: rtl/encoder_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : encoder_ctrl
// Purpose  : Command FSM and periodic snapshot sampler for an encoder core.
//            Optional position-limit trip when ENCODER_CTRL_LIMIT_EN is defined.
// Revision : 1.0
// =============================================================================
module encoder_ctrl #(
   parameter int PERIOD_W = 16,
   parameter int SEQ_W    = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [1:0]          cmd_op,
   input  logic [PERIOD_W-1:0] sample_period,
   output logic                core_enable,
   output logic                core_clr_pos,
   input  logic signed [31:0]  core_position,
   input  logic signed [31:0]  core_velocity,
   input  logic                core_direction,
   output logic                smp_valid,
   input  logic                smp_ready,
   output logic [31:0]         smp_position,
   output logic [31:0]         smp_velocity,
   output logic                smp_direction,
   output logic [SEQ_W-1:0]    smp_seq,
   output logic                running,
   output logic                overrun
`ifdef ENCODER_CTRL_LIMIT_EN
   ,
   input  logic signed [31:0]  pos_limit_lo,
   input  logic signed [31:0]  pos_limit_hi,
   output logic                limit_hit
`endif
);

   localparam logic [1:0] c_OP_START = 2'b01;
   localparam logic [1:0] c_OP_STOP  = 2'b10;
   localparam logic [1:0] c_OP_ZERO  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ret_run;
   logic                 w_ret_run_nxt;

   logic                 r_cmd_ready;
   logic                 r_core_enable;
   logic                 r_core_clr_pos;
   logic                 r_running;
   logic                 r_overrun;
   logic [PERIOD_W-1:0]  r_cnt;
   logic [SEQ_W-1:0]     r_seq;
   logic                 r_smp_valid;
   logic [31:0]          r_smp_position;
   logic [31:0]          r_smp_velocity;
   logic                 r_smp_direction;
   logic [SEQ_W-1:0]     r_smp_seq;

   logic                 w_cmd_acc;
   logic                 w_start_acc;
   logic                 w_limit_trip;
   logic [PERIOD_W-1:0]  w_period_m1;
   logic                 w_tick;
   logic                 w_cap;

   assign w_cmd_acc   = cmd_valid && r_cmd_ready;
   assign w_start_acc = w_cmd_acc && (cmd_op == c_OP_START);

`ifdef ENCODER_CTRL_LIMIT_EN
   logic r_limit_hit;

   assign w_limit_trip = (r_state == S_RUN) &&
                         ((core_position < pos_limit_lo) || (core_position > pos_limit_hi));
   assign limit_hit    = r_limit_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_limit_hit <= 1'b0;
      end else if (w_limit_trip) begin
         r_limit_hit <= 1'b1;
      end else if (w_start_acc) begin
         r_limit_hit <= 1'b0;
      end
   end
`else
   assign w_limit_trip = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_ret_run <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ret_run <= w_ret_run_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ret_run_nxt = r_ret_run;
      unique case (r_state)
         S_IDLE: begin
            if (w_cmd_acc) begin
               case (cmd_op)
                  c_OP_START: w_state_nxt = S_RUN;
                  c_OP_ZERO: begin
                     w_state_nxt   = S_CLEAR;
                     w_ret_run_nxt = 1'b0;
                  end
                  default: w_state_nxt = S_IDLE;
               endcase
            end
         end
         S_RUN: begin
            // A limit trip overrides any command accepted in the same cycle.
            if (w_limit_trip) begin
               w_state_nxt = S_IDLE;
            end else if (w_cmd_acc) begin
               case (cmd_op)
                  c_OP_STOP: w_state_nxt = S_IDLE;
                  c_OP_ZERO: begin
                     w_state_nxt   = S_CLEAR;
                     w_ret_run_nxt = 1'b1;
                  end
                  default: w_state_nxt = S_RUN;
               endcase
            end
         end
         S_CLEAR: w_state_nxt = r_ret_run ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Control outputs are registered images of the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd_ready    <= 1'b0;
         r_core_enable  <= 1'b0;
         r_core_clr_pos <= 1'b0;
         r_running      <= 1'b0;
      end else begin
         r_cmd_ready    <= (w_state_nxt != S_CLEAR);
         r_core_enable  <= (w_state_nxt == S_RUN) || ((w_state_nxt == S_CLEAR) && w_ret_run_nxt);
         r_core_clr_pos <= (w_state_nxt == S_CLEAR);
         r_running      <= (w_state_nxt == S_RUN);
      end
   end

   assign w_period_m1 = sample_period - PERIOD_W'(1);
   assign w_tick      = (r_state == S_RUN) && (sample_period != '0) && (r_cnt >= w_period_m1);
   assign w_cap       = w_tick && (!r_smp_valid || smp_ready);

   // Counter sits at 0 outside RUN, so every entry into RUN starts from 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if ((r_state != S_RUN) || (sample_period == '0) || w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + PERIOD_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_seq           <= '0;
         r_smp_valid     <= 1'b0;
         r_smp_position  <= '0;
         r_smp_velocity  <= '0;
         r_smp_direction <= 1'b0;
         r_smp_seq       <= '0;
         r_overrun       <= 1'b0;
      end else begin
         if (w_tick) begin
            r_seq <= r_seq + SEQ_W'(1);
         end
         if (w_cap) begin
            r_smp_valid     <= 1'b1;
            r_smp_position  <= core_position;
            r_smp_velocity  <= core_velocity;
            r_smp_direction <= core_direction;
            r_smp_seq       <= r_seq;
         end else if (r_smp_valid && smp_ready) begin
            r_smp_valid <= 1'b0;
         end
         if (w_tick && !w_cap) begin
            r_overrun <= 1'b1;
         end else if (w_start_acc) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign core_enable   = r_core_enable;
   assign core_clr_pos  = r_core_clr_pos;
   assign running       = r_running;
   assign overrun       = r_overrun;
   assign smp_valid     = r_smp_valid;
   assign smp_position  = r_smp_position;
   assign smp_velocity  = r_smp_velocity;
   assign smp_direction = r_smp_direction;
   assign smp_seq       = r_smp_seq;

endmodule
`default_nettype wire
